bf_cmult_sched: RTL and testbench

//  Sequencer that time-shares one signed BF_MULT_BITS x BF_MULT_BITS butterfly

---
 rtl/bf_cmult_sched_if.sv | 32 +++
 rtl/bf_cmult_sched.sv | 114 +++++++++++
 tb/tb_bf_cmult_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bf_cmult_sched_if.sv
// Operand, shared-multiplier and result signals of the complex-multiply sequencer.
// The slave modport is the sequencer side; the master modport is its environment.
interface bf_cmult_sched_if #(
  parameter int W        = 16,
  parameter int OUT_BITS = 33
);
  logic                  xInValid;
  logic                  xInReady;
  logic                  xConj;
  logic signed [W-1:0]   xAr;
  logic signed [W-1:0]   xAi;
  logic signed [W-1:0]   xBr;
  logic signed [W-1:0]   xBi;
  logic signed [W-1:0]   xMultiplicand;
  logic signed [W-1:0]   xMultiplier;
  logic signed [2*W-1:0] xProduct;
  logic                  xOutValid;
  logic                  xOutReady;
  logic signed [OUT_BITS-1:0] xPr;
  logic signed [OUT_BITS-1:0] xPi;
  logic                  xBusy;

  modport slave (
    input  xInValid, xConj, xAr, xAi, xBr, xBi, xProduct, xOutReady,
    output xInReady, xMultiplicand, xMultiplier, xOutValid, xPr, xPi, xBusy
  );

  modport master (
    output xInValid, xConj, xAr, xAi, xBr, xBi, xProduct, xOutReady,
    input  xInReady, xMultiplicand, xMultiplier, xOutValid, xPr, xPi, xBusy
  );
endinterface

// File: rtl/bf_cmult_sched.sv
// Complex multiply P = A*B or A*conj(B) using one shared signed multiplier,
// issuing four real products in M0..M3 and registering the result in DONE.
module bf_cmult_sched #(
  parameter int BF_MULT_BITS = 16,
  parameter int OUT_BITS     = 33
) (
  input  logic             xClk,
  input  logic             xRst_n,
  bf_cmult_sched_if.slave  bus
);
  localparam int W  = BF_MULT_BITS;
  localparam int PW = 2 * BF_MULT_BITS;

  typedef enum logic [2:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    DONE
  } state_t;

  state_t state, state_nx;

  logic signed [W-1:0]        ar_q, ai_q, br_q, bi_q;
  logic                       conj_q;
  logic signed [OUT_BITS-1:0] re_q, im_q;
  logic signed [OUT_BITS-1:0] pr_q, pi_q;
  logic                       out_valid_q;

  logic                       in_ready;
  logic                       accept;
  logic signed [W-1:0]        mcand;
  logic signed [W-1:0]        mplier;
  logic signed [OUT_BITS-1:0] p_ext;

  assign in_ready = (state == IDLE) || ((state == DONE) && bus.xOutReady);
  assign accept   = bus.xInValid && in_ready;
  assign p_ext    = {{(OUT_BITS-PW){bus.xProduct[PW-1]}}, bus.xProduct};

  always_ff @(posedge xClk or negedge xRst_n) begin
    if (!xRst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = M0;
      M0:      state_nx = M1;
      M1:      state_nx = M2;
      M2:      state_nx = M3;
      M3:      state_nx = DONE;
      DONE:    if (bus.xOutReady) state_nx = accept ? M0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mcand  = '0;
    mplier = '0;
    unique case (state)
      M0: begin mcand = ar_q; mplier = br_q; end
      M1: begin mcand = ai_q; mplier = bi_q; end
      M2: begin mcand = ar_q; mplier = bi_q; end
      M3: begin mcand = ai_q; mplier = br_q; end
      default: ;
    endcase
  end

  // Conjugate flips the sign of Bi, which only affects the M1 and M2 terms.
  always_ff @(posedge xClk or negedge xRst_n) begin
    if (!xRst_n) begin
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      conj_q      <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      pr_q        <= '0;
      pi_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        ar_q   <= bus.xAr;
        ai_q   <= bus.xAi;
        br_q   <= bus.xBr;
        bi_q   <= bus.xBi;
        conj_q <= bus.xConj;
      end
      unique case (state)
        M0: re_q <= p_ext;
        M1: re_q <= conj_q ? (re_q + p_ext) : (re_q - p_ext);
        M2: im_q <= conj_q ? -p_ext : p_ext;
        M3: begin
          pr_q        <= re_q;
          pi_q        <= im_q + p_ext;
          out_valid_q <= 1'b1;
        end
        DONE: if (bus.xOutReady) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.xInReady      = in_ready;
  assign bus.xMultiplicand = mcand;
  assign bus.xMultiplier   = mplier;
  assign bus.xOutValid     = out_valid_q;
  assign bus.xPr           = pr_q;
  assign bus.xPi           = pi_q;
  assign bus.xBusy         = (state != IDLE);
endmodule

// File: tb/tb_bf_cmult_sched.sv
// Directed and streamed checks of bf_cmult_sched against hand-computed and
// golden complex-product values, with the shared multiplier modelled here.
module tb_bf_cmult_sched;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bf_cmult_sched_if #(.W(16), .OUT_BITS(33)) bus ();

  assign bus.xProduct = bus.xMultiplicand * bus.xMultiplier;

  bf_cmult_sched #(.BF_MULT_BITS(16), .OUT_BITS(33)) dut (
    .xClk   (clk),
    .xRst_n (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic signed [15:0] ar, ai, br, bi, input logic cj);
    bus.xAr = ar; bus.xAi = ai; bus.xBr = br; bus.xBi = bi; bus.xConj = cj;
    bus.xInValid = 1'b1;
  endtask

  // One full transaction from IDLE with xOutReady held high.
  task automatic run_op(input string tag, input logic signed [15:0] ar, ai, br, bi,
                        input logic cj, input longint er, ei);
    @(negedge clk);
    bus.xOutReady = 1'b1;
    drive(ar, ai, br, bi, cj);
    #1 check({tag, "_in_ready"}, bus.xInReady, 1);
    @(posedge clk);
    @(negedge clk);
    bus.xInValid = 1'b0;
    check({tag, "_m0_mcand"}, bus.xMultiplicand, ar);
    check({tag, "_m0_mplier"}, bus.xMultiplier, br);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_early"}, bus.xOutValid, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, bus.xOutValid, 1);
    check({tag, "_pr"}, bus.xPr, er);
    check({tag, "_pi"}, bus.xPi, ei);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, bus.xOutValid, 0);
    check({tag, "_idle"}, bus.xBusy, 0);
  endtask

  localparam int N_STREAM = 1000;
  longint exp_re[$];
  longint exp_im[$];

  initial begin
    bus.xInValid  = 1'b0;
    bus.xOutReady = 1'b0;
    drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    bus.xInValid  = 1'b0;

    // Reset state
    #12;
    check("rst_valid", bus.xOutValid, 0);
    check("rst_busy", bus.xBusy, 0);
    check("rst_pr", bus.xPr, 0);
    check("rst_pi", bus.xPi, 0);
    check("rst_in_ready", bus.xInReady, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // T1..T3
    run_op("t1", 16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b0, -9, 38);
    run_op("t2", 16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b1, 39, 2);
    run_op("t3a", -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1'b0, 0, 64'sd2147483648);
    run_op("t3b", -16'sd32768, 16'sd0, 16'sd0, 16'sd1, 1'b0, 0, -32768);

    // T4: stall in DONE with a new operand set waiting, then release + accept
    @(negedge clk);
    bus.xOutReady = 1'b0;
    drive(16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.xInValid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    drive(16'sd2, 16'sd0, 16'sd7, -16'sd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_valid", bus.xOutValid, 1);
      check("t4_hold_pr", bus.xPr, -5);
      check("t4_hold_pi", bus.xPi, 10);
      check("t4_hold_in_ready", bus.xInReady, 0);
      @(negedge clk);
    end
    bus.xOutReady = 1'b1;
    #1 check("t4_release_in_ready", bus.xInReady, 1);
    @(posedge clk);
    @(negedge clk);
    bus.xInValid = 1'b0;
    check("t4_m0_valid", bus.xOutValid, 0);
    check("t4_m0_busy", bus.xBusy, 1);
    check("t4_m0_mcand", bus.xMultiplicand, 2);
    check("t4_m0_mplier", bus.xMultiplier, 7);
    check("t4_pr_kept", bus.xPr, -5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4_valid_early", bus.xOutValid, 0);
    @(posedge clk);
    @(negedge clk);
    check("t4_valid", bus.xOutValid, 1);
    check("t4_pr", bus.xPr, 14);
    check("t4_pi", bus.xPi, 2);
    @(posedge clk);
    @(negedge clk);
    check("t4_done", bus.xOutValid, 0);

    // T5: asynchronous reset while in M2
    drive(16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.xInValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_busy_m2", bus.xBusy, 1);
    check("t5_mcand_m2", bus.xMultiplicand, 3);
    rst_n = 1'b0;
    #1;
    check("t5_valid", bus.xOutValid, 0);
    check("t5_busy", bus.xBusy, 0);
    check("t5_pr", bus.xPr, 0);
    check("t5_pi", bus.xPi, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t5_in_ready", bus.xInReady, 1);
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.xOutValid) seen++;
      end
      check("t5_no_stale", seen, 0);
    end

    // T6: random stream with downstream stalls against the golden model
    begin
      int sent = 0, got = 0, cyc = 0;
      logic acc = 1'b0;
      logic signed [15:0] ar, ai, br, bi;
      logic cj;
      longint er, ei;
      while (got < N_STREAM && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        if (acc) begin
          bus.xInValid = 1'b0;
          acc = 1'b0;
        end
        if (!bus.xInValid && sent < N_STREAM && $urandom_range(0, 3) != 0) begin
          ar = 16'($urandom); ai = 16'($urandom);
          br = 16'($urandom); bi = 16'($urandom);
          cj = 1'($urandom);
          drive(ar, ai, br, bi, cj);
        end
        bus.xOutReady = ($urandom_range(0, 2) != 0);
        #1;
        if (bus.xInValid && bus.xInReady) begin
          if (cj) begin
            er = longint'(ar) * br + longint'(ai) * bi;
            ei = longint'(ai) * br - longint'(ar) * bi;
          end else begin
            er = longint'(ar) * br - longint'(ai) * bi;
            ei = longint'(ar) * bi + longint'(ai) * br;
          end
          exp_re.push_back(er);
          exp_im.push_back(ei);
          sent++;
          acc = 1'b1;
        end
        if (bus.xOutValid && bus.xOutReady) begin
          got++;
          if (exp_re.size() == 0) begin
            check("t6_unexpected_result", 1, 0);
          end else begin
            check("t6_pr", bus.xPr, exp_re.pop_front());
            check("t6_pi", bus.xPi, exp_im.pop_front());
          end
        end
      end
      check("t6_result_count", got, N_STREAM);
      check("t6_sent_count", sent, N_STREAM);
      check("t6_drained", exp_re.size(), 0);
      @(negedge clk);
      bus.xInValid  = 1'b0;
      bus.xOutReady = 1'b1;
      begin
        int extra = 0;
        repeat (10) begin
          @(negedge clk);
          if (bus.xOutValid) extra++;
        end
        check("t6_no_duplicate", extra, 0);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
